// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, opcode-class helpers and the stall/fill FSM state type.
package wisc_pkg;

  localparam logic [3:0] OpLw  = 4'b1000;
  localparam logic [3:0] OpSw  = 4'b1001;
  localparam logic [3:0] OpLlb = 4'b1010;
  localparam logic [3:0] OpLhb = 4'b1011;
  localparam logic [3:0] OpB   = 4'b1100;
  localparam logic [3:0] OpBr  = 4'b1101;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDFill = 2'd1,
    StIFill = 2'd2
  } state_e;

  function automatic logic is_flag_writer(logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110};
  endfunction

  // SW store data is bypassed mem-to-mem, so its rt never forces a load-use stall.
  function automatic logic uses_rt(logic [3:0] op);
    return !(op inside {OpSw, OpLlb, OpLhb});
  endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational ID-stage hazard checks: load-use, branch-on-flags and BR-register dependencies.
module id_hazard_detect
  import wisc_pkg::*;
(
  input  logic [3:0] id_opcode_i,
  input  logic [3:0] id_rs_i,
  input  logic [3:0] id_rt_i,
  input  logic [3:0] ex_opcode_i,
  input  logic [3:0] ex_rd_i,
  input  logic       ex_regwrite_i,
  input  logic [3:0] mem_opcode_i,
  input  logic [3:0] mem_rd_i,
  output logic       load_use_o,
  output logic       flag_hazard_o,
  output logic       br_hazard_o
);

  always_comb begin
    load_use_o = (ex_opcode_i == OpLw) && (ex_rd_i != 4'd0) &&
                 ((ex_rd_i == id_rs_i) || (uses_rt(id_opcode_i) && (ex_rd_i == id_rt_i)));

    flag_hazard_o = (id_opcode_i == OpB) && is_flag_writer(ex_opcode_i);

    // BR reads its target in ID, so both an EX producer and a MEM load must drain first.
    br_hazard_o = (id_opcode_i == OpBr) && (id_rs_i != 4'd0) &&
                  ((ex_regwrite_i && (ex_rd_i == id_rs_i)) ||
                   ((mem_opcode_i == OpLw) && (mem_rd_i == id_rs_i)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: ID hazard stalls, taken-branch flush and I/D cache fill sequencing.
module hazard_stall_ctrl
  import wisc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ID_opcode,
  input  logic [3:0]       ID_rs,
  input  logic [3:0]       ID_rt,
  input  logic             branch_taken,
  input  logic [3:0]       EX_opcode,
  input  logic [3:0]       EX_rd,
  input  logic             EX_RegWrite,
  input  logic [3:0]       MEM_opcode,
  input  logic [3:0]       MEM_rd,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             fill_done,
  output logic             fill_req,
  output logic             fill_is_d,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic             fill_req_q, fill_req_d;
  logic             fill_is_d_q, fill_is_d_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use, flag_hazard, br_hazard, hazard, fill_ack;

  id_hazard_detect u_id_hazard_detect (
    .id_opcode_i   (ID_opcode),
    .id_rs_i       (ID_rs),
    .id_rt_i       (ID_rt),
    .ex_opcode_i   (EX_opcode),
    .ex_rd_i       (EX_rd),
    .ex_regwrite_i (EX_RegWrite),
    .mem_opcode_i  (MEM_opcode),
    .mem_rd_i      (MEM_rd),
    .load_use_o    (load_use),
    .flag_hazard_o (flag_hazard),
    .br_hazard_o   (br_hazard)
  );

  assign hazard   = load_use | flag_hazard | br_hazard;
  // A completion pulse only counts while a request is actually outstanding.
  assign fill_ack = fill_done & fill_req_q;

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    case (state_q)
      StDFill: begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        EX_MEM_write = 1'b0;
        MEM_WB_write = 1'b0;
      end
      default: begin
        if (hazard) begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end else if (state_q == StIFill) begin
          PC_write    = 1'b0;
          IF_ID_flush = 1'b1;
        end else if (branch_taken) begin
          IF_ID_flush = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fill_req_d  = fill_req_q;
    fill_is_d_d = fill_is_d_q;
    case (state_q)
      StRun: begin
        if (dcache_miss) begin
          state_d     = StDFill;
          fill_req_d  = 1'b1;
          fill_is_d_d = 1'b1;
        end else if (icache_miss) begin
          state_d     = StIFill;
          fill_req_d  = 1'b1;
          fill_is_d_d = 1'b0;
        end
      end
      StDFill: begin
        if (fill_ack) begin
          fill_req_d  = 1'b0;
          fill_is_d_d = 1'b0;
          state_d     = icache_miss ? StIFill : StRun;
        end
      end
      StIFill: begin
        // Entering from DFILL leaves the request low for one cycle; raise it here.
        if (fill_ack) begin
          state_d    = StRun;
          fill_req_d = 1'b0;
        end else if (!fill_req_q) begin
          fill_req_d = 1'b1;
        end
      end
      default: begin
        state_d    = StRun;
        fill_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      fill_req_q  <= 1'b0;
      fill_is_d_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_req_q  <= fill_req_d;
      fill_is_d_q <= fill_is_d_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset withdraws an in-flight request immediately rather than at the next edge.
  assign fill_req  = fill_req_q & ~rst;
  assign fill_is_d = fill_is_d_q;
  assign stall_cnt = stall_cnt_q;

endmodule
